hit_arbiter: RTL and testbench
==============================

HIT_ARBITER -- requirements
Module: hit_arbiter

Interface
REQ-001 The block SHALL have parameter RESP_WAIT, default 2, giving the number of cycles after a hit pulse in which hit_success is accepted.
REQ-002 The block SHALL have parameter SCORE_W, default 8, giving the per-player score width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: high while the round engine is running.
REQ-006 The block SHALL have port score_clear, input, 1 bit: zeroes both scores.
REQ-007 The block SHALL have ports p0_hit and p1_hit, input, 1 bit each: one-cycle hit request pulse from player keypad.
REQ-008 The block SHALL have ports p0_index and p1_index, input, 4 bits each: hole index sampled with the request.
REQ-009 The block SHALL have port hit_success, input, 1 bit: hit-confirmed pulse from the round engine.
REQ-010 The block SHALL have port hit, output, 1 bit: one-cycle hit pulse to the round engine.
REQ-011 The block SHALL have port hit_index, output, 4 bits: granted hole index, valid while hit=1.
REQ-012 The block SHALL have ports p0_busy and p1_busy, output, 1 bit each: the player's pending slot is full.
REQ-013 The block SHALL have ports p0_ok and p1_ok, output, 1 bit each: one-cycle credit pulse.
REQ-014 The block SHALL have ports p0_score and p1_score, output, SCORE_W bits each: confirmed hit counts.
REQ-015 The block SHALL have port leader, output, 2 bits: 00 tie, 01 player0 ahead, 10 player1 ahead; registered.

Function
REQ-016 Each player SHALL have a one-deep pending slot {valid, index}; pX_hit=1 with the slot empty and enable=1 captures pX_index at that edge; pX_busy = slot valid.
REQ-017 A request arriving while the slot is full SHALL be dropped without affecting the stored index.
REQ-018 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-019 IDLE->ISSUE SHALL occur when any slot is valid; the granted slot is cleared and its index and player id are registered on that edge.
REQ-020 If both slots are valid in IDLE, the grant SHALL go to the player not granted last; last_grant resets to player1, so player0 wins the first tie.
REQ-021 In ISSUE, hit SHALL be 1 for exactly one cycle and hit_index SHALL equal the registered index; ISSUE->WAIT is unconditional.
REQ-022 In WAIT, a wait counter SHALL run 1..RESP_WAIT.
REQ-023 When hit_success=1 in a WAIT cycle, the FSM SHALL go WAIT->IDLE, pulse the granted player's pX_ok on the next cycle and increment that player's score.
REQ-024 When the counter reaches RESP_WAIT without hit_success, the FSM SHALL go WAIT->IDLE with no credit (miss).
REQ-025 hit_success received outside WAIT SHALL be ignored.
REQ-026 Latency SHALL be as follows: a request at edge t into an empty slot with FSM in IDLE gives slot valid after t, ISSUE (hit=1) in cycle t+2, and the earliest credit pulse in cycle t+4.
REQ-027 Scores SHALL saturate at 2^SCORE_W-1 with no wrap; pX_ok still pulses at saturation.
REQ-028 leader SHALL be recomputed from the scores every cycle and registered, lagging a score change by one cycle.
REQ-029 score_clear=1 SHALL zero both scores at the edge; if a credit coincides with score_clear, clear wins.
REQ-030 When enable=0, slots SHALL be cleared, new requests ignored, and the FSM SHALL enter IDLE at the next edge; an in-flight grant is abandoned with no credit; scores are held.
REQ-031 A simultaneous request and grant of the same player in one cycle SHALL refill the slot, because the slot clears and captures on the same edge.

Reset
REQ-032 On rst=1 at an edge the block SHALL set: FSM=IDLE, slots empty, last_grant=player1, wait counter=0, hit=0, hit_index=0, pX_busy=0, pX_ok=0, scores=0, leader=00.
REQ-033 rst SHALL take priority over enable and score_clear, and reset mid-grant SHALL suppress any pending credit.

Verification
REQ-034 Single hit scenario SHALL be covered: p0_hit with index 5 at cycle 0, hit_success in cycle 3 -> hit=1 and hit_index=5 in cycle 2, p0_ok in cycle 4, p0_score=1, leader=01 in cycle 5.
REQ-035 Tie arbitration scenario SHALL be covered: p0_hit with index 3 and p1_hit with index 9 in the same cycle with no hit_success -> hit_index 3 issued first, 9 issued after the p0 miss window, scores 0, leader=00.
REQ-036 Drop scenario SHALL be covered: p1_hit with index 2, then p1_hit with index 7 while p1_busy=1 -> only index 2 issued; index 7 never appears.
REQ-037 Saturation scenario SHALL be covered: SCORE_W=2 with four confirmed p1 hits -> p1_score 1,2,3,3; four p1_ok pulses; leader=10.
REQ-038 Abort scenario SHALL be covered: enable dropped in the WAIT cycle with hit_success asserted the same cycle -> no credit, FSM in IDLE, busy flags 0 the next cycle.
REQ-039 Reset/clear scenario SHALL be covered: score_clear coincident with a credit -> score 0; rst mid-ISSUE -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/hit_arbiter_if.sv
// Signal bundle between the hit arbiter and its environment (player keypads and round engine).
// The arbiter takes the slave view; whoever drives requests and confirmations takes the master view.
interface hit_arbiter_if #(
  parameter int SCORE_W = 8
);
  logic               enable;
  logic               score_clear;
  logic               p0_hit;
  logic               p1_hit;
  logic [3:0]         p0_index;
  logic [3:0]         p1_index;
  logic               hit_success;
  logic               hit;
  logic [3:0]         hit_index;
  logic               p0_busy;
  logic               p1_busy;
  logic               p0_ok;
  logic               p1_ok;
  logic [SCORE_W-1:0] p0_score;
  logic [SCORE_W-1:0] p1_score;
  logic [1:0]         leader;

  modport master (
    output enable, score_clear, p0_hit, p1_hit, p0_index, p1_index, hit_success,
    input  hit, hit_index, p0_busy, p1_busy, p0_ok, p1_ok, p0_score, p1_score, leader
  );

  modport slave (
    input  enable, score_clear, p0_hit, p1_hit, p0_index, p1_index, hit_success,
    output hit, hit_index, p0_busy, p1_busy, p0_ok, p1_ok, p0_score, p1_score, leader
  );
endinterface

// File: rtl/hit_arbiter.sv
// Two-player hit arbiter: one-deep request slot per player, alternating grant on ties,
// one-cycle hit pulse to the round engine, bounded confirmation window, saturating scores.
module hit_arbiter #(
  parameter int RESP_WAIT = 2,
  parameter int SCORE_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  hit_arbiter_if.slave bus
);

  localparam int                 CNT_W     = (RESP_WAIT < 2) ? 1 : $clog2(RESP_WAIT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(RESP_WAIT);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic [3:0]              idx_q, idx_d;
  logic [1:0]              slot_v_q, slot_v_d;
  logic [1:0][3:0]         slot_idx_q, slot_idx_d;
  logic [1:0]              ok_q, ok_d;
  logic [1:0][SCORE_W-1:0] score_q, score_d;
  logic [1:0]              leader_q, leader_d;

  logic                    grant_v;
  logic                    grant_p;
  logic                    credit;
  logic [1:0]              req;
  logic [1:0][3:0]         req_idx;

  assign req     = {bus.p1_hit, bus.p0_hit};
  assign req_idx = {bus.p1_index, bus.p0_index};

  // Grant/confirmation sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    grant_v = 1'b0;
    grant_p = 1'b0;
    credit  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|slot_v_q) begin
          grant_v = 1'b1;
          // On a tie the player who did not win last time goes first.
          grant_p = (slot_v_q == 2'b11) ? ~last_q : slot_v_q[1];
          gnt_d   = grant_p;
          idx_d   = slot_idx_q[grant_p];
          last_d  = grant_p;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.hit_success) begin
          credit  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Engine stopped: abandon whatever is in flight without credit.
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      grant_v = 1'b0;
      credit  = 1'b0;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      last_d  = last_q;
    end
  end

  // Pending slots, credit pulses, scores and leader flag.
  always_comb begin
    slot_v_d   = slot_v_q;
    slot_idx_d = slot_idx_q;
    ok_d       = '0;
    score_d    = score_q;

    for (int p = 0; p < 2; p++) begin
      // Clearing before capturing lets a request refill the slot being granted on the same edge.
      if (grant_v && (grant_p == 1'(p))) slot_v_d[p] = 1'b0;
      if (!bus.enable) begin
        slot_v_d[p] = 1'b0;
      end else if (req[p] && !slot_v_d[p]) begin
        slot_v_d[p]   = 1'b1;
        slot_idx_d[p] = req_idx[p];
      end

      ok_d[p] = credit && (gnt_q == 1'(p));

      if (bus.score_clear) begin
        score_d[p] = '0;
      end else if (ok_d[p] && (score_q[p] != SCORE_MAX)) begin
        score_d[p] = score_q[p] + SCORE_W'(1);
      end
    end

    if (score_q[0] > score_q[1]) begin
      leader_d = 2'b01;
    end else if (score_q[1] > score_q[0]) begin
      leader_d = 2'b10;
    end else begin
      leader_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      idx_q      <= '0;
      slot_v_q   <= '0;
      slot_idx_q <= '0;
      ok_q       <= '0;
      score_q    <= '0;
      leader_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      slot_v_q   <= slot_v_d;
      slot_idx_q <= slot_idx_d;
      ok_q       <= ok_d;
      score_q    <= score_d;
      leader_q   <= leader_d;
    end
  end

  assign bus.hit       = (state_q == S_ISSUE);
  assign bus.hit_index = idx_q;
  assign bus.p0_busy   = slot_v_q[0];
  assign bus.p1_busy   = slot_v_q[1];
  assign bus.p0_ok     = ok_q[0];
  assign bus.p1_ok     = ok_q[1];
  assign bus.p0_score  = score_q[0];
  assign bus.p1_score  = score_q[1];
  assign bus.leader    = leader_q;

  hit_one_cycle: assert property (@(posedge clk) disable iff (rst) bus.hit |=> !bus.hit);
  ok_exclusive:  assert property (@(posedge clk) !(bus.p0_ok && bus.p1_ok));

endmodule

// File: tb/tb_hit_arbiter.sv
// Bench for hit_arbiter: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a transaction-level model of the arbitration rules.
module tb_hit_arbiter;

  localparam int RESP_WAIT = 2;
  localparam int SCORE_W   = 2;
  localparam int MAX_SCORE = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hit_arbiter_if #(.SCORE_W(SCORE_W)) bus ();

  hit_arbiter #(
    .RESP_WAIT(RESP_WAIT),
    .SCORE_W  (SCORE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A grant lives from its issue cycle (age 0) through RESP_WAIT confirmation cycles.
  bit   m_pend_v[2];
  int   m_pend_idx[2];
  bit   m_active;
  int   m_pl, m_idx, m_age, m_last;
  int   m_score[2];
  bit   m_ok[2];
  int   m_leader;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend_v[p] = 1'b0; m_pend_idx[p] = 0; m_score[p] = 0; m_ok[p] = 1'b0;
    end
    m_active = 1'b0; m_pl = 0; m_idx = 0; m_age = 0; m_last = 1; m_leader = 0;
  endtask

  task automatic model_step();
    int credit, g, new_leader;
    bit hreq[2];
    int hidx[2];
    hreq[0] = bus.p0_hit; hreq[1] = bus.p1_hit;
    hidx[0] = int'(bus.p0_index); hidx[1] = int'(bus.p1_index);
    if (rst) begin
      model_reset();
      return;
    end
    new_leader = (m_score[0] > m_score[1]) ? 1 : (m_score[1] > m_score[0]) ? 2 : 0;
    credit = -1;
    if (!bus.enable) begin
      m_active = 1'b0;
      m_pend_v[0] = 1'b0; m_pend_v[1] = 1'b0;
    end else begin
      if (m_active) begin
        if (m_age >= 1 && bus.hit_success) begin
          credit = m_pl; m_active = 1'b0;
        end else if (m_age == RESP_WAIT) begin
          m_active = 1'b0;
        end else begin
          m_age++;
        end
      end else if (m_pend_v[0] || m_pend_v[1]) begin
        g = (m_pend_v[0] && m_pend_v[1]) ? 1 - m_last : (m_pend_v[0] ? 0 : 1);
        m_active = 1'b1; m_age = 0; m_pl = g; m_idx = m_pend_idx[g]; m_last = g;
        m_pend_v[g] = 1'b0;
      end
      for (int p = 0; p < 2; p++)
        if (hreq[p] && !m_pend_v[p]) begin
          m_pend_v[p] = 1'b1; m_pend_idx[p] = hidx[p];
        end
    end
    for (int p = 0; p < 2; p++) begin
      m_ok[p] = (credit == p);
      if (bus.score_clear) m_score[p] = 0;
      else if (credit == p && m_score[p] < MAX_SCORE) m_score[p]++;
    end
    m_leader = new_leader;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit exp_hit;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_hit = m_active && (m_age == 0);
        check("m_hit", int'(bus.hit), int'(exp_hit));
        if (exp_hit) check("m_hit_index", int'(bus.hit_index), m_idx);
        check("m_p0_busy", int'(bus.p0_busy), int'(m_pend_v[0]));
        check("m_p1_busy", int'(bus.p1_busy), int'(m_pend_v[1]));
        check("m_p0_ok", int'(bus.p0_ok), int'(m_ok[0]));
        check("m_p1_ok", int'(bus.p1_ok), int'(m_ok[1]));
        check("m_p0_score", int'(bus.p0_score), m_score[0]);
        check("m_p1_score", int'(bus.p1_score), m_score[1]);
        check("m_leader", int'(bus.leader), m_leader);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic idle_inputs();
    bus.p0_hit = 1'b0; bus.p1_hit = 1'b0;
    bus.hit_success = 1'b0; bus.score_clear = 1'b0;
  endtask

  task automatic request(input int p, input int idx);
    if (p == 0) begin bus.p0_hit = 1'b1; bus.p0_index = 4'(idx); end
    else        begin bus.p1_hit = 1'b1; bus.p1_index = 4'(idx); end
  endtask

  function automatic int busy_of(input int p);
    return (p == 0) ? int'(bus.p0_busy) : int'(bus.p1_busy);
  endfunction

  function automatic int ok_of(input int p);
    return (p == 0) ? int'(bus.p0_ok) : int'(bus.p1_ok);
  endfunction

  function automatic int score_of(input int p);
    return (p == 0) ? int'(bus.p0_score) : int'(bus.p1_score);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_hit"}, int'(bus.hit), 0);
    check({tag, "_hit_index"}, int'(bus.hit_index), 0);
    check({tag, "_busy"}, int'({bus.p1_busy, bus.p0_busy}), 0);
    check({tag, "_ok"}, int'({bus.p1_ok, bus.p0_ok}), 0);
    check({tag, "_p0_score"}, int'(bus.p0_score), 0);
    check({tag, "_p1_score"}, int'(bus.p1_score), 0);
    check({tag, "_leader"}, int'(bus.leader), 0);
  endtask

  // Request in cycle 0 from an idle arbiter, optional confirm (and clear) in cycle 3.
  // Returns on the negedge of cycle 5.
  task automatic do_hit(input int p, input int idx, input bit succ, input bit clr,
                        input int exp_score);
    cyc(); request(p, idx);
    cyc(); idle_inputs();
    check("dh_busy", busy_of(p), 1);
    cyc();
    check("dh_hit", int'(bus.hit), 1);
    check("dh_hit_index", int'(bus.hit_index), idx);
    cyc(); bus.hit_success = succ; bus.score_clear = clr;
    cyc(); idle_inputs();
    check("dh_ok", ok_of(p), int'(succ));
    check("dh_score", score_of(p), exp_score);
    cyc();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sat_exp[4];
    sat_exp = '{1, 2, 3, 3};
    bus.enable = 1'b1; bus.p0_index = '0; bus.p1_index = '0;
    idle_inputs();

    // Reset
    wait_n(2);
    check_reset_values("rst");
    rst = 1'b0; chk_en = 1'b1;
    cyc();

    // Tie: player0 wins first after reset, player1 follows after the miss window
    cyc(); request(0, 3); request(1, 9);
    cyc(); idle_inputs();
    check("tie_busy0", int'(bus.p0_busy), 1);
    check("tie_busy1", int'(bus.p1_busy), 1);
    cyc();
    check("tie_hit_a", int'(bus.hit), 1);
    check("tie_index_a", int'(bus.hit_index), 3);
    wait_n(3);
    check("tie_gap", int'(bus.hit), 0);
    cyc();
    check("tie_hit_b", int'(bus.hit), 1);
    check("tie_index_b", int'(bus.hit_index), 9);
    wait_n(3);
    check("tie_p0_score", int'(bus.p0_score), 0);
    check("tie_p1_score", int'(bus.p1_score), 0);
    check("tie_leader", int'(bus.leader), 0);

    // Single confirmed hit
    do_hit(0, 5, 1'b1, 1'b0, 1);
    check("single_leader", int'(bus.leader), 1);

    // Drop: second p1 request while its slot is full and not being granted
    cyc(); request(0, 1);
    cyc(); idle_inputs(); request(1, 2);
    cyc(); idle_inputs(); request(1, 7);
    check("drop_hit_p0", int'(bus.hit_index), 1);
    check("drop_busy1", int'(bus.p1_busy), 1);
    cyc(); idle_inputs();
    wait_n(3);
    check("drop_hit_p1", int'(bus.hit), 1);
    check("drop_index_p1", int'(bus.hit_index), 2);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("drop_no_more", int'(bus.hit), 0);
    end

    // Saturation with SCORE_W=2
    cyc(); bus.score_clear = 1'b1;
    cyc(); idle_inputs();
    for (int k = 0; k < 4; k++) do_hit(1, k + 4, 1'b1, 1'b0, sat_exp[k]);
    check("sat_leader", int'(bus.leader), 2);

    // Abort: enable dropped in WAIT together with hit_success
    cyc(); request(0, 6);
    cyc(); idle_inputs();
    cyc(); request(1, 8);
    check("abort_hit", int'(bus.hit), 1);
    cyc(); idle_inputs(); bus.enable = 1'b0; bus.hit_success = 1'b1;
    cyc(); bus.hit_success = 1'b0; bus.enable = 1'b1;
    check("abort_ok0", int'(bus.p0_ok), 0);
    check("abort_busy0", int'(bus.p0_busy), 0);
    check("abort_busy1", int'(bus.p1_busy), 0);
    check("abort_score0", int'(bus.p0_score), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("abort_idle", int'(bus.hit), 0);
    end

    // Clear coincident with a credit: clear wins
    do_hit(0, 10, 1'b1, 1'b0, 1);
    do_hit(0, 11, 1'b1, 1'b1, 0);
    check("clr_p1_score", int'(bus.p1_score), 0);

    // Reset in the ISSUE cycle
    do_hit(1, 13, 1'b1, 1'b0, 1);
    cyc(); request(1, 12);
    cyc(); idle_inputs();
    cyc();
    check("rst_issue_hit", int'(bus.hit), 1);
    rst = 1'b1;
    cyc(); rst = 1'b0; bus.hit_success = 1'b1;
    check_reset_values("rst_mid");
    cyc(); bus.hit_success = 1'b0;
    check("rst_no_credit", int'(bus.p1_ok), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst             = ($urandom_range(0, 499) == 0);
      bus.enable      = ($urandom_range(0, 19) != 0);
      bus.p0_hit      = ($urandom_range(0, 3) == 0);
      bus.p1_hit      = ($urandom_range(0, 3) == 0);
      bus.p0_index    = 4'($urandom_range(0, 15));
      bus.p1_index    = 4'($urandom_range(0, 15));
      bus.hit_success = ($urandom_range(0, 2) == 0);
      bus.score_clear = ($urandom_range(0, 49) == 0);
    end
    cyc(); rst = 1'b0; bus.enable = 1'b1; idle_inputs();
    wait_n(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
